// File: rtl/mul_div_unit.sv
// +--------------------------------------------------------------------------+
// | mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.   |
// | Optional macro MDU_FAST_MULT_EN: single-cycle combinational multiply.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_sign = 2'd2;
  localparam logic [5:0] c_last = 6'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [5:0]         r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic               w_div_zero;
  logic               w_neg_q;
  logic               w_neg_r;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_signed   = ~op[0];
  assign w_div_zero = op[1] && (b == '0);
  // Divide-by-zero bypasses all sign fixing so HI/LO come out raw.
  assign w_neg_q    = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !w_div_zero;
  assign w_neg_r    = w_signed && a[WIDTH-1] && !w_div_zero;
  assign w_mag_a    = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_mag_b    = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply: {partial, multiplier} shifts right, adding the multiplicand on a 1 LSB.
  assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag};
  assign w_mul_next = r_acc[0] ? {w_add, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: {rem, quot} shifts left; the shifted remainder needs one extra bit.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_mag});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_mag;
  assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {r_acc[2*WIDTH-2:0], 1'b0};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      w_res_lo = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
      w_res_hi = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_mag   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_div   <= op[1];
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            r_cnt   <= '0;
            r_state <= c_calc;
            if (op[1]) begin
              r_mag <= w_mag_b;
              r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_mag <= w_mag_a;
              r_acc <= {{WIDTH{1'b0}}, w_mag_b};
            end
            if (w_div_zero) begin
              r_acc   <= {a, {WIDTH{1'b1}}};
              r_state <= c_sign;
            end
`ifdef MDU_FAST_MULT_EN
            else if (!op[1]) begin
              r_acc   <= w_fast_prod;
              r_state <= c_sign;
            end
`endif
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        c_calc: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_last) r_state <= c_sign;
        end
        c_sign: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != c_idle);
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// +--------------------------------------------------------------------------+
// | tb_mul_div_unit: scoreboard bench for mul_div_unit (MDU_FAST_MULT_EN     |
// | aware). Revision: 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        start;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        scb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating divide gives the remainder the dividend's sign.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    lat = 33;
    p   = '0;
    case (o)
      2'b00: begin p = 64'(sa * sbv); lat = MUL_LAT; end
      2'b01: begin p = {32'b0, av} * {32'b0, bv}; lat = MUL_LAT; end
      default: begin
        if (bv == 0) begin
          p   = {av, 32'hFFFF_FFFF};
          lat = 1;
        end else if (o == 2'b10) begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {av % bv, av / bv};
        end
      end
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        mon_e = scb.pop_front();
        chk("result_hi", 64'(hi), 64'(mon_e.hi));
        chk("result_lo", 64'(lo), 64'(mon_e.lo));
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Called at a negedge with busy low; returns at the negedge where busy falls.
  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int pulse_at, input bit with_lo);
    logic [31:0] eh, el;
    int          lat, n;
    exp_t        e;
    ref_model(o, av, bv, eh, el, lat);
    op = o; a = av; b = bv; start = 1'b1;
    if (with_lo) begin lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    e.hi = eh; e.lo = el; e.cyc = cyc + lat;
    scb.push_back(e);
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 1 || n == lat) begin
        chk("hold_hi", 64'(hi), 64'(model_hi));
        chk("hold_lo", 64'(lo), 64'(model_lo));
      end
      if (n == pulse_at) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_cycles", 64'(n), 64'(lat));
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic do_mt(input bit to_hi, input logic [31:0] v);
    if (to_hi) hi_we = 1'b1; else lo_we = 1'b1;
    wdata = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (to_hi) begin
      chk("mthi", 64'(hi), 64'(v));
      model_hi = v;
    end else begin
      chk("mtlo", 64'(lo), 64'(v));
      model_lo = v;
    end
  endtask

  task automatic do_reset_mid();
`ifdef MDU_FAST_MULT_EN
    op = 2'b11; a = 32'd100; b = 32'd7;
`else
    op = 2'b01; a = 32'd5; b = 32'd6;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_hi", 64'(hi), 64'd0);
    chk("mid_reset_lo", 64'(lo), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_done", 64'(done), 64'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; a = '0; b = '0; op = '0; start = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
    do_op(2'b11, 32'd100, 32'd0, 0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'b01, 32'd5, 32'd6, 5, 1'b0);
    do_mt(1'b1, 32'h1234_5678);
    do_mt(1'b0, 32'h0BAD_F00D);
    do_op(2'b01, 32'd2, 32'd3, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), rnd_operand(), rnd_operand(), 0, 1'b0);
    end

    do_reset_mid();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(scb.size()), 64'd0);
    chk("final_hi", 64'(hi), 64'(model_hi));
    chk("final_lo", 64'(lo), 64'(model_lo));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the execute stage, beside `alu`. It takes the same register-file operands `a`/`b`, runs MULT/MULTU/DIV/DIVU over multiple cycles, and holds the results in HI/LO. Writeback reads HI/LO for MFHI/MFLO. While `busy` is high, the control unit stalls the PC and any dependent HI/LO access.

## Interface
- Parameters:
  - `WIDTH`, default 32: operand width. HI/LO are each `WIDTH` bits.
- Ports:
  - `clk`  in  1  rising-edge clock.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `a`  in  32  operand A; dividend for divide ops.
  - `b`  in  32  operand B; divisor for divide ops.
  - `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
  - `start`  in  1  launch `op`; sampled only in IDLE.
  - `hi_we`  in  1  MTHI: write `wdata` into HI.
  - `lo_we`  in  1  MTLO: write `wdata` into LO.
  - `wdata`  in  32  data for MTHI/MTLO.
  - `hi`  out  32  HI register.
  - `lo`  out  32  LO register.
  - `busy`  out  1  operation in progress.
  - `done`  out  1  one-cycle pulse; HI/LO were updated at the previous edge.

## Operation
- States and transitions:
  - IDLE: `start` → CALC, or → SIGN for divide-by-zero.
  - CALC: 32 iterations, then → SIGN.
  - SIGN: always → IDLE.
- At accept, latch `op` and the operand signs.
  - Store operand magnitudes: two's-complement absolute value for signed ops, raw value for unsigned ops.
  - Clear the 6-bit iteration counter.
- Multiply:
  - Shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - In SIGN, negate the 64-bit product if the operand signs differ (signed ops only). HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division on a 64-bit {rem, quot} register, one quotient bit per cycle.
  - In SIGN (signed ops only): negate the quotient if signs differ; the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- Special cases:
  - 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0 (natural result of the magnitude datapath).
  - Divide by zero (`b`==0 at accept): skip CALC. SIGN writes HI = `a`, LO = 0xFFFFFFFF.
- `start` while `busy`: ignored.
- `hi_we`/`lo_we`:
  - While `busy`: ignored.
  - In IDLE without `start`: write at the next edge.
  - In IDLE with `start` in the same cycle: `start` wins and the write is dropped.

## Timing
- Reset (async, `rst_n`=0): state = IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0. Takes effect immediately, including mid-operation; the partial result is discarded.
- `start` accepted at edge E0.
  - `busy` is high from E0 up to the edge that leaves SIGN.
  - CALC iterations occur on edges E1..E32. SIGN is at E33: HI/LO are written and state returns to IDLE.
  - `done` is high for the cycle after E33. `busy` is low in that same cycle, so a new `start` may be accepted at E34.
- Divide by zero: SIGN at E1; `done` is high in the cycle after E1.
- `hi`/`lo` are registered outputs. They hold their old values throughout CALC and never show intermediate values.
- `done` is exactly one cycle and is never asserted outside the SIGN→IDLE transition.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU use a combinational 64-bit product of the magnitudes and skip CALC.
  - SIGN occurs at E1; `done` is high in the cycle after E1.
  - Divide timing is unchanged.
- Undefined: all multiplies take the iterative 32-cycle path described above.

## Test plan
- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` in the cycle after E33 (after E1 with `MDU_FAST_MULT_EN`).
- MULT `a`=0xFFFFFFFD (−3), `b`=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` is high for exactly the E0..E33 window.
- DIV `a`=0xFFFFFFF9 (−7), `b`=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU `a`=100, `b`=7 → LO=14, HI=2.
- DIVU `a`=100, `b`=0 → HI=0x00000064, LO=0xFFFFFFFF, with `done` in the cycle after E1.
- Start MULTU 5×6, then pulse `start` with new operands at E5 → ignored; final result HI=0, LO=30. Repeat the same op and drop `rst_n` at E10 → `hi`=`lo`=0 and `busy`=0 immediately; no `done` follows.
- In IDLE, `hi_we`=1, `wdata`=0x12345678 → `hi`=0x12345678 after the edge. `lo_we` asserted in the same cycle as `start` (MULTU 2×3) → the write is dropped and LO=6 at completion.
